// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues in-order imem requests and buffers returned words for decode.
// Optional feature macro FETCH_MISALIGN_EN: trap misaligned redirect targets instead of masking them.
module fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            inst_valid_d,
    output logic [31:0]     inst_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc4_d,
    input  logic            stall_d,
    input  logic            redirect_d,
    input  logic [XLEN-1:0] target_d,
    input  logic            redirect_e,
    input  logic [XLEN-1:0] target_e,
    output logic            fetch_misalign,
    output logic [XLEN-1:0] misalign_pc
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = CW + 2;

    logic [31:0]     inst_buf [DEPTH];
    logic [XLEN-1:0] pc_buf   [DEPTH];
    logic [AW-1:0]   head, tail;
    logic [CW-1:0]   count, outstanding, drop, inflight, flush_drop;
    logic [XLEN-1:0] pc, rsp_pc, raw_target, target;
    logic            run, halt, redirect, req_fire, pop, rsp_keep, rsp_drop, room;

    always_comb begin
        redirect   = redirect_e || redirect_d;
        raw_target = redirect_e ? target_e : target_d;
`ifdef FETCH_MISALIGN_EN
        target     = raw_target;
`else
        target     = raw_target & ~XLEN'(3);
`endif
        inflight   = drop + outstanding;
        flush_drop = inflight - CW'(imem_rsp_valid && (inflight != '0));
        // stale responses still occupy imem slots, so they count against DEPTH
        room           = (SW'(count) + SW'(inflight)) < SW'(DEPTH);
        imem_req_valid = !reset && run && !redirect && !halt && room;
        imem_req_addr  = pc;
        req_fire       = imem_req_valid && imem_req_ready;
        rsp_keep       = imem_rsp_valid && (drop == '0) && !redirect && !reset;
        rsp_drop       = imem_rsp_valid && (drop != '0);
        inst_valid_d   = (count != '0);
        inst_d         = inst_buf[head];
        pc_d           = pc_buf[head];
        pc4_d          = pc_buf[head] + XLEN'(4);
        pop            = inst_valid_d && !stall_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            outstanding <= '0;
            drop        <= flush_drop;
            run         <= 1'b0;
        end else begin
            run <= 1'b1;
            if (redirect) begin
                pc          <= target;
                rsp_pc      <= target;
                head        <= '0;
                tail        <= '0;
                count       <= '0;
                outstanding <= '0;
                drop        <= flush_drop;
            end else begin
                if (req_fire) pc <= pc + XLEN'(4);
                if (rsp_keep) begin
                    tail   <= tail + AW'(1);
                    rsp_pc <= rsp_pc + XLEN'(4);
                end
                if (pop) head <= head + AW'(1);
                if (rsp_drop) drop <= drop - CW'(1);
                count       <= count + CW'(rsp_keep) - CW'(pop);
                outstanding <= outstanding + CW'(req_fire) - CW'(rsp_keep);
            end
        end
    end

    // the PC of each kept word is implied by the sequential request stream since the last flush
    always_ff @(posedge clk) begin
        if (rsp_keep) begin
            inst_buf[tail] <= imem_rsp_data;
            pc_buf[tail]   <= rsp_pc;
        end
    end

`ifdef FETCH_MISALIGN_EN
    logic            misalign_q;
    logic [XLEN-1:0] misalign_pc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_q    <= 1'b0;
            misalign_pc_q <= '0;
        end else if (redirect) begin
            if (raw_target[1:0] != 2'b00) begin
                misalign_q    <= 1'b1;
                misalign_pc_q <= raw_target;
            end else begin
                misalign_q    <= 1'b0;
            end
        end
    end

    always_comb begin
        halt           = misalign_q;
        fetch_misalign = misalign_q;
        misalign_pc    = misalign_pc_q;
    end
`else
    always_comb begin
        halt           = 1'b0;
        fetch_misalign = 1'b0;
        misalign_pc    = '0;
    end
`endif

endmodule
